// File: rtl/text_console_writer.sv
// text_console_writer: cursor-tracking ASCII stream to 80x25 char RAM write port with row/screen clear
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 25,
  parameter int ADDR_W = 11,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic [7:0]        in_attr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic [ADDR_W-1:0] cursor_index
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(COLS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS-1);
  localparam logic [15:0] BLANK = {DEFAULT_ATTR, 8'h20};
  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;
  state_t state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [ADDR_W-1:0] cursor_n, clr_addr, clr_addr_n, wr_address_n, row_start;
  logic [15:0] wr_data_n;
  logic wr_en_n, adv;
  assign row_start = row == ROW_MAX ? '0 : cursor_index - ADDR_W'(col) + STEP;
  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    cursor_n = cursor_index;
    clr_addr_n = clr_addr;
    wr_en_n = 1'b0;
    wr_address_n = wr_address;
    wr_data_n = wr_data;
    adv = 1'b0;
    case (state)
      CLR_ALL: begin
        wr_en_n = 1'b1;
        wr_address_n = clr_addr;
        wr_data_n = BLANK;
        clr_addr_n = clr_addr + 1'b1;
        if (clr_addr == LAST) begin
          state_n = IDLE;
          row_n = '0;
          col_n = '0;
          cursor_n = '0;
        end
      end
      CLR_ROW: begin
        wr_en_n = 1'b1;
        wr_address_n = clr_addr;
        wr_data_n = BLANK;
        clr_addr_n = clr_addr + 1'b1;
        if (clr_addr == cursor_index + SPAN) state_n = IDLE;
      end
      IDLE: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            wr_en_n = 1'b1;
            wr_address_n = cursor_index;
            wr_data_n = {in_attr, in_char};
            if (col != COL_MAX) begin
              col_n = col + 1'b1;
              cursor_n = cursor_index + 1'b1;
            end else adv = 1'b1;
          end else if (in_char == 8'h0D) begin
            col_n = '0;
            cursor_n = cursor_index - ADDR_W'(col);
          end else if (in_char == 8'h0A) begin
            adv = 1'b1;
          end else if (in_char == 8'h08 && col != '0) begin
            col_n = col - 1'b1;
            cursor_n = cursor_index - 1'b1;
            wr_en_n = 1'b1;
            wr_address_n = cursor_index - 1'b1;
            wr_data_n = BLANK;
          end else if (in_char == 8'h0C) begin
            state_n = CLR_ALL;
            clr_addr_n = '0;
          end
          if (adv) begin
            col_n = '0;
            row_n = row == ROW_MAX ? '0 : row + 1'b1;
            cursor_n = row_start;
            clr_addr_n = row_start;
            state_n = CLR_ROW;
          end
        end
      end
      default: state_n = CLR_ALL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_ALL;
      col <= '0;
      row <= '0;
      cursor_index <= '0;
      clr_addr <= '0;
      wr_en <= 1'b0;
      wr_address <= '0;
      wr_data <= '0;
      in_ready <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      cursor_index <= cursor_n;
      clr_addr <= clr_addr_n;
      wr_en <= wr_en_n;
      wr_address <= wr_address_n;
      wr_data <= wr_data_n;
      in_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
    end
  end
endmodule
